// File: rtl/seq_divide_unit_pkg.sv
// Purpose: shared constants for the iterative divider (state encodings, default width).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_divide_unit_pkg;

    localparam int DIV_WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ITER = 2'd2,
        ST_DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/bus_sync2.sv
// Purpose: two-flop synchroniser for a bus of slow, quasi-static switch inputs.
// Latency: 2 clock cycles from d_i to q_o.
// Backpressure: none; samples every cycle.
module bus_sync2 #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // Two back-to-back flops; the first may go metastable, the second settles it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/seq_divide_unit.sv
// Purpose: restoring divider on synchronised switch operands, auto-launched on operand change.
// Latency: trigger in IDLE at N -> result_valid/outputs at N+WIDTH+2; switch edge to result <= WIDTH+5.
// Backpressure: none; operand changes during a division are picked up once back in IDLE.
module seq_divide_unit
    import seq_divide_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy,
    output logic             result_valid
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] sync_a;
    logic [WIDTH-1:0] sync_b;

    div_state_e       state_q, state_d;
    logic             first_run_q;
    logic [WIDTH-1:0] last_a_q, last_b_q;
    logic [WIDTH-1:0] rem_q, quo_q, divisor_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] quotient_q, remainder_q;
    logic             dbz_q;

    logic             trigger;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             fits;
    logic [WIDTH-1:0] rem_nxt, quo_nxt;

    bus_sync2 #(.W(WIDTH)) u_sync_a (
        .clk_i  (clock),
        .rst_ni (reset),
        .d_i    (a_in),
        .q_o    (sync_a)
    );

    bus_sync2 #(.W(WIDTH)) u_sync_b (
        .clk_i  (clock),
        .rst_ni (reset),
        .d_i    (b_in),
        .q_o    (sync_b)
    );

    assign trigger = first_run_q | (sync_a != last_a_q) | (sync_b != last_b_q);

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    // The subtraction is one bit wider so its MSB is a clean borrow flag.
    always_comb begin
        trial   = {rem_q, quo_q[WIDTH-1]};
        diff    = trial - {1'b0, divisor_q};
        fits    = ~diff[WIDTH];
        rem_nxt = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_nxt = {quo_q[WIDTH-2:0], fits};
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (trigger) state_d = ST_LOAD;
            ST_LOAD: state_d = ST_ITER;
            ST_ITER: if (count_q == '0) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy         = (state_q == ST_LOAD) || (state_q == ST_ITER);
        result_valid = (state_q == ST_DONE);
    end

    // Datapath: operand capture, iteration registers and held results.
    // Results are loaded on the edge into DONE so they are already valid
    // while result_valid is high, and stay untouched until the next DONE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            first_run_q <= 1'b1;
            last_a_q    <= '0;
            last_b_q    <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            divisor_q   <= '0;
            count_q     <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (trigger) begin
                        last_a_q    <= sync_a;
                        last_b_q    <= sync_b;
                        first_run_q <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    rem_q     <= '0;
                    quo_q     <= last_a_q;
                    divisor_q <= last_b_q;
                    count_q   <= CW'(WIDTH - 1);
                end
                ST_ITER: begin
                    rem_q <= rem_nxt;
                    quo_q <= quo_nxt;
                    if (count_q == '0) begin
                        quotient_q  <= quo_nxt;
                        remainder_q <= rem_nxt;
                        dbz_q       <= (divisor_q == '0);
                    end else begin
                        count_q <= count_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divide_unit.sv
module tb_seq_divide_unit;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] a_in, b_in;
    logic [3:0] quotient, remainder;
    logic       div_by_zero, busy, result_valid;

    logic [7:0] a8, b8;
    logic [7:0] quotient8, remainder8;
    logic       dbz8, busy8, rv8;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    seq_divide_unit #(.WIDTH(4)) u_dut (
        .clock        (clock),
        .reset        (reset),
        .a_in         (a_in),
        .b_in         (b_in),
        .quotient     (quotient),
        .remainder    (remainder),
        .div_by_zero  (div_by_zero),
        .busy         (busy),
        .result_valid (result_valid)
    );

    seq_divide_unit #(.WIDTH(8)) u_dut8 (
        .clock        (clock),
        .reset        (reset),
        .a_in         (a8),
        .b_in         (b8),
        .quotient     (quotient8),
        .remainder    (remainder8),
        .div_by_zero  (dbz8),
        .busy         (busy8),
        .result_valid (rv8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Wait for the next 4-bit result pulse; flag any output change before it.
    task automatic wait4(input int budget, output bit got, output int cyc, output bit moved);
        logic [3:0] q0, r0;
        logic       z0;
        q0 = quotient; r0 = remainder; z0 = div_by_zero;
        got = 0; cyc = 0; moved = 0;
        while (!got && cyc < budget) begin
            @(negedge clock);
            cyc++;
            if (result_valid) got = 1;
            else if (quotient !== q0 || remainder !== r0 || div_by_zero !== z0) moved = 1;
        end
    endtask

    task automatic wait8(input int budget, output bit got, output bit moved);
        logic [7:0] q0, r0;
        logic       z0;
        int         cyc;
        q0 = quotient8; r0 = remainder8; z0 = dbz8;
        got = 0; cyc = 0; moved = 0;
        while (!got && cyc < budget) begin
            @(negedge clock);
            cyc++;
            if (rv8) got = 1;
            else if (quotient8 !== q0 || remainder8 !== r0 || dbz8 !== z0) moved = 1;
        end
    endtask

    task automatic run4(input string tag, input int a, input int b);
        bit got, moved;
        int cyc;
        a_in = 4'(a); b_in = 4'(b);
        wait4(40, got, cyc, moved);
        chk({tag, " pulse"}, 32'(got), 1);
        chk({tag, " q"}, 32'(quotient),    (b == 0) ? 15 : a / b);
        chk({tag, " r"}, 32'(remainder),   (b == 0) ? a  : a % b);
        chk({tag, " dbz"}, 32'(div_by_zero), (b == 0) ? 1 : 0);
        chk({tag, " hold"}, 32'(moved), 0);
    endtask

    task automatic run8(input int a, input int b);
        bit got, moved;
        a8 = 8'(a); b8 = 8'(b);
        wait8(40, got, moved);
        chk("w8 pulse", 32'(got), 1);
        chk("w8 q", 32'(quotient8),   (b == 0) ? 255 : a / b);
        chk("w8 r", 32'(remainder8),  (b == 0) ? a   : a % b);
        chk("w8 dbz", 32'(dbz8), (b == 0) ? 1 : 0);
        chk("w8 hold", 32'(moved), 0);
    endtask

    task automatic wait_busy(input int budget, output int cyc);
        cyc = 0;
        while (!busy && cyc < budget) begin
            @(negedge clock);
            cyc++;
        end
        chk("busy seen", 32'(busy), 1);
    endtask

    initial begin
        bit got, moved;
        int cyc, raw, n, busyc, pulses, pa, pb;

        reset = 1'b0;
        a_in = '0; b_in = '0; a8 = '0; b8 = '0;
        repeat (3) @(negedge clock);
        chk("rst q",    32'(quotient), 0);
        chk("rst r",    32'(remainder), 0);
        chk("rst dbz",  32'(div_by_zero), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst rv",   32'(result_valid), 0);
        chk("rst q8",   32'(quotient8), 0);

        // First run after reset: 0/0.
        reset = 1'b1;
        wait4(40, got, cyc, moved);
        chk("first pulse", 32'(got), 1);
        chk("first q",   32'(quotient), 15);
        chk("first r",   32'(remainder), 0);
        chk("first dbz", 32'(div_by_zero), 1);
        pulses = 0;
        repeat (15) begin
            @(negedge clock);
            if (result_valid) pulses++;
        end
        chk("no repeat pulse", 32'(pulses), 0);

        // 13/4: latency and busy length.
        a_in = 4'd13; b_in = 4'd4;
        wait_busy(20, raw);
        n = 0; busyc = 0;
        while (!result_valid && n < 20) begin
            if (busy) busyc++;
            @(negedge clock);
            n++;
        end
        chk("trig to pulse", 32'(n + 1), 6);
        chk("busy cycles", 32'(busyc), 5);
        chk("raw to pulse ok", 32'((raw + n) <= 9), 1);
        chk("13/4 q", 32'(quotient), 3);
        chk("13/4 r", 32'(remainder), 1);
        chk("13/4 dbz", 32'(div_by_zero), 0);

        // Divide by zero, then recovery.
        run4("7/0", 7, 0);
        run4("7/7", 7, 7);

        // Divisor changes mid-ITER: finish 15/9, then relaunch 15/2.
        a_in = 4'd15; b_in = 4'd9;
        wait_busy(20, cyc);
        repeat (2) @(negedge clock);
        b_in = 4'd2;
        wait4(40, got, cyc, moved);
        chk("mid pulse1", 32'(got), 1);
        chk("mid q1", 32'(quotient), 1);
        chk("mid r1", 32'(remainder), 6);
        @(negedge clock);
        chk("gap rv", 32'(result_valid), 0);
        chk("gap idle", 32'(busy), 0);
        @(negedge clock);
        chk("relaunch", 32'(busy), 1);
        wait4(40, got, cyc, moved);
        chk("mid pulse2", 32'(got), 1);
        chk("mid q2", 32'(quotient), 7);
        chk("mid r2", 32'(remainder), 1);
        chk("mid hold", 32'(moved), 0);

        // Asynchronous reset mid-ITER.
        @(negedge clock);
        a_in = 4'd9; b_in = 4'd4;
        wait_busy(20, cyc);
        repeat (2) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        chk("arst q",    32'(quotient), 0);
        chk("arst r",    32'(remainder), 0);
        chk("arst dbz",  32'(div_by_zero), 0);
        chk("arst busy", 32'(busy), 0);
        chk("arst rv",   32'(result_valid), 0);
        @(negedge clock);
        reset = 1'b1;
        wait4(40, got, cyc, moved);
        chk("post-rst 0/0 q", 32'(quotient), 15);
        chk("post-rst 0/0 dbz", 32'(div_by_zero), 1);
        wait4(40, got, cyc, moved);
        chk("post-rst pulse", 32'(got), 1);
        chk("post-rst q", 32'(quotient), 2);
        chk("post-rst r", 32'(remainder), 1);
        chk("post-rst dbz", 32'(div_by_zero), 0);

        // Exhaustive 4-bit sweep.
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                run4("sweep", a, b);

        // 8-bit instance: its held result is from the post-reset 0/0 run.
        chk("w8 init q",   32'(quotient8), 255);
        chk("w8 init r",   32'(remainder8), 0);
        chk("w8 init dbz", 32'(dbz8), 1);
        run8(255, 16);
        run8(200, 7);
        run8(0, 5);
        run8(128, 0);
        run8(17, 255);
        run8(250, 250);
        run8(99, 10);
        pa = 99; pb = 10;
        for (int i = 0; i < 30; i++) begin
            int ra, rb;
            ra = $urandom_range(255);
            rb = $urandom_range(255);
            if (ra == pa && rb == pb) rb = (rb + 1) % 256;
            run8(ra, rb);
            pa = ra; pb = rb;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
